rf_arbiter: RTL and testbench

Shares the single register-file port between two requesters: port 0 is the system command controller and port 1 is a secondary master such as a configuration or status poller. Requests are arbitrated round-robin, and the winning command is registered and issued to the register file as a one-cycle WrEn/RdEn strobe. Read data is routed back to the requester that issued the read. The block sits between the requesters and the register file in the CLK domain.

---
 rtl/rf_arb_pkg.sv | 19 +
 rtl/rr_arb2.sv | 26 ++
 rtl/rf_arbiter.sv | 163 ++++++++++++++++
 tb/tb_rf_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file port arbiter.
// Holds the controller state encoding, requester ids and default widths.
// Imported by rr_arb2 and rf_arbiter.
package rf_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    localparam logic REQ_ID_0 = 1'b0;
    localparam logic REQ_ID_1 = 1'b1;

    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_ADDR_WIDTH     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 15;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port not granted last.
// Purely combinational, zero latency.
// Ports: req[1:0] requests, last = id granted previously; gnt one-hot, winner = granted id.
module rr_arb2
    import rf_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       winner
);

    always_comb begin
        gnt    = 2'b00;
        winner = REQ_ID_0;
        if (req == 2'b11) begin
            winner = ~last;
        end else if (req[1]) begin
            winner = REQ_ID_1;
        end
        if (req != 2'b00) begin
            gnt[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/rf_arbiter.sv
// Shares one register-file port between two requesters with round-robin arbitration.
// Latency: GNT same cycle (combinational in IDLE), strobe next cycle, RVLD one cycle after RdData_Valid.
// Ports: REQx/WEx/ADDRx/WDATAx in, GNTx/RDATAx/RVLDx/RERRx out; Address/WrEn/RdEn/WrData to the RF,
// RdData/RdData_Valid back. Build option RF_ARB_TIMEOUT_EN enables the RD_WAIT timeout and RERRx.
module rf_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ0,
    input  logic                  REQ1,
    input  logic                  WE0,
    input  logic                  WE1,
    input  logic [ADDR_WIDTH-1:0] ADDR0,
    input  logic [ADDR_WIDTH-1:0] ADDR1,
    input  logic [DATA_WIDTH-1:0] WDATA0,
    input  logic [DATA_WIDTH-1:0] WDATA1,
    output logic                  GNT0,
    output logic                  GNT1,
    output logic [DATA_WIDTH-1:0] RDATA0,
    output logic [DATA_WIDTH-1:0] RDATA1,
    output logic                  RVLD0,
    output logic                  RVLD1,
    output logic                  RERR0,
    output logic                  RERR1,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [DATA_WIDTH-1:0] WrData,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_Valid
);

    state_t                state, state_nxt;
    logic                  last_q;
    logic                  own_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic [1:0]            pick_gnt;
    logic                  pick_id;
    logic                  grant;
    logic                  rd_done;
    logic                  rd_tmo;

    rr_arb2 u_pick (
        .req    ({REQ1, REQ0}),
        .last   (last_q),
        .gnt    (pick_gnt),
        .winner (pick_id)
    );

    // Grants are suppressed while RST is high so nothing is accepted into a block being reset.
    assign grant   = (state == IDLE) && !RST && (pick_gnt != 2'b00);
    // Valid returns outside RD_WAIT are stray and dropped here.
    assign rd_done = (state == RD_WAIT) && RdData_Valid;

    always_comb begin
        state_nxt = state;
        GNT0      = 1'b0;
        GNT1      = 1'b0;
        WrEn      = 1'b0;
        RdEn      = 1'b0;
        Address   = '0;
        WrData    = '0;
        case (state)
            IDLE: begin
                if (grant) begin
                    GNT0      = pick_gnt[0];
                    GNT1      = pick_gnt[1];
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!RST) begin
                    Address = addr_q;
                    WrData  = wdata_q;
                    WrEn    = we_q;
                    RdEn    = !we_q;
                end
                state_nxt = we_q ? IDLE : RD_WAIT;
            end
            RD_WAIT: begin
                if (rd_done || rd_tmo) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            last_q  <= REQ_ID_1;  // makes port 0 win the first tie
            own_q   <= REQ_ID_0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            RDATA0  <= '0;
            RDATA1  <= '0;
            RVLD0   <= 1'b0;
            RVLD1   <= 1'b0;
        end else begin
            state <= state_nxt;
            RVLD0 <= rd_done && (own_q == REQ_ID_0);
            RVLD1 <= rd_done && (own_q == REQ_ID_1);
            if (grant) begin
                own_q   <= pick_id;
                last_q  <= pick_id;
                we_q    <= pick_id ? WE1 : WE0;
                addr_q  <= pick_id ? ADDR1 : ADDR0;
                wdata_q <= pick_id ? WDATA1 : WDATA0;
            end
            if (rd_done) begin
                if (own_q == REQ_ID_1) begin
                    RDATA1 <= RdData;
                end else begin
                    RDATA0 <= RdData;
                end
            end
        end
    end

`ifdef RF_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_q;

    // tmo_cnt_q counts RD_WAIT cycles already spent, so the abort lands on the last allowed cycle.
    assign rd_tmo = (state == RD_WAIT) && !RdData_Valid &&
                    (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            tmo_cnt_q <= '0;
            RERR0     <= 1'b0;
            RERR1     <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                tmo_cnt_q <= '0;
            end else if (state == RD_WAIT) begin
                tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            end
            RERR0 <= rd_tmo && (own_q == REQ_ID_0);
            RERR1 <= rd_tmo && (own_q == REQ_ID_1);
        end
    end
`else
    // Without the timeout option RD_WAIT waits for the register file indefinitely.
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign rd_tmo     = 1'b0;
    assign RERR0      = 1'b0;
    assign RERR1      = 1'b0;
`endif

endmodule

// File: tb/tb_rf_arbiter.sv
// Bench for rf_arbiter: directed stimulus, transaction-level reference model, per-cycle compare.
// The model schedules expected strobes from grant/return timestamps rather than tracking FSM states.
module tb_rf_arbiter;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int TMO = 15;

    logic          CLK = 1'b0;
    logic          RST;
    logic          REQ0, REQ1, WE0, WE1;
    logic [AW-1:0] ADDR0, ADDR1, Address;
    logic [DW-1:0] WDATA0, WDATA1, RDATA0, RDATA1, WrData, RdData;
    logic          GNT0, GNT1, RVLD0, RVLD1, RERR0, RERR1, WrEn, RdEn, RdData_Valid;

    always #5 CLK = ~CLK;

    rf_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .GNT0(GNT0), .GNT1(GNT1), .RDATA0(RDATA0), .RDATA1(RDATA1),
        .RVLD0(RVLD0), .RVLD1(RVLD1), .RERR0(RERR0), .RERR1(RERR1),
        .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData),
        .RdData(RdData), .RdData_Valid(RdData_Valid)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit            model_on = 1'b0;
    bit            m_last = 1'b1;
    int            m_issue_at = -1;   // cycle the captured command must appear on the RF port
    int            m_free_at = 0;     // first cycle a new grant may happen
    bit            m_rd_open = 1'b0;  // a read is outstanding
    int            m_open_since = 0;  // first cycle a return is accepted
    bit            m_own, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;
    logic [DW-1:0] m_rdata [2] = '{8'h00, 8'h00};
    bit   [1:0]    m_rvld = 2'b00, m_rerr = 2'b00;

    always @(negedge CLK) begin
        if (model_on) begin
            bit   [1:0]    e_gnt, nx_rvld, nx_rerr;
            bit            e_we, e_re, w;
            logic [AW-1:0] e_addr;
            logic [DW-1:0] e_wd, e_rd0, e_rd1;
            e_gnt = 2'b00; e_we = 1'b0; e_re = 1'b0; e_addr = '0; e_wd = '0;
            e_rd0 = m_rdata[0]; e_rd1 = m_rdata[1];
            nx_rvld = 2'b00; nx_rerr = 2'b00;
            if (RST) begin
                m_issue_at = -1; m_rd_open = 1'b0; m_free_at = cyc + 1; m_last = 1'b1;
                m_rdata[0] = '0; m_rdata[1] = '0;
            end else if (cyc == m_issue_at) begin
                e_addr = m_addr; e_wd = m_wd;
                if (m_we) begin
                    e_we = 1'b1; m_free_at = cyc + 1;
                end else begin
                    e_re = 1'b1; m_rd_open = 1'b1; m_open_since = cyc + 1;
                end
                m_issue_at = -1;
            end else if (m_rd_open) begin
                if (RdData_Valid) begin
                    nx_rvld[m_own] = 1'b1; m_rdata[m_own] = RdData;
                    m_rd_open = 1'b0; m_free_at = cyc + 1;
                end
`ifdef RF_ARB_TIMEOUT_EN
                else if (cyc - m_open_since + 1 >= TMO) begin
                    nx_rerr[m_own] = 1'b1; m_rd_open = 1'b0; m_free_at = cyc + 1;
                end
`endif
            end else if (m_issue_at < 0 && cyc >= m_free_at && (REQ0 || REQ1)) begin
                w = (REQ0 && REQ1) ? !m_last : REQ1;
                e_gnt[w] = 1'b1;
                m_own  = w;
                m_we   = w ? WE1 : WE0;
                m_addr = w ? ADDR1 : ADDR0;
                m_wd   = w ? WDATA1 : WDATA0;
                m_last = w;
                m_issue_at = cyc + 1;
                m_free_at = 1 << 30;
            end
            chk("GNT0", GNT0, e_gnt[0]);
            chk("GNT1", GNT1, e_gnt[1]);
            chk("WrEn", WrEn, e_we);
            chk("RdEn", RdEn, e_re);
            chk("Address", Address, e_addr);
            chk("WrData", WrData, e_wd);
            chk("RVLD0", RVLD0, m_rvld[0]);
            chk("RVLD1", RVLD1, m_rvld[1]);
            chk("RERR0", RERR0, m_rerr[0]);
            chk("RERR1", RERR1, m_rerr[1]);
            chk("RDATA0", RDATA0, e_rd0);
            chk("RDATA1", RDATA1, e_rd1);
            m_rvld = nx_rvld;
            m_rerr = nx_rerr;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic at_neg();
        @(negedge CLK);
    endtask

    initial begin
        int order [$];
        int exp_order [4] = '{0, 1, 0, 1};
        int both_cnt;
        int rerr_seen;
        bit got;

        RST = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0; WE0 = 1'b0; WE1 = 1'b0;
        ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
        RdData = '0; RdData_Valid = 1'b0;
        model_on = 1'b1;
        step(); step();
        RST = 1'b0;

        // port 0 write 0x5A to address 3
        REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 4'd3; WDATA0 = 8'h5A;
        at_neg(); chk("t1_gnt0", GNT0, 1); chk("t1_gnt1", GNT1, 0);
        step(); REQ0 = 1'b0; WE0 = 1'b0; ADDR0 = '0; WDATA0 = '0;
        at_neg(); chk("t1_wren", WrEn, 1); chk("t1_addr", Address, 3); chk("t1_wrdata", WrData, 8'h5A);
        step();
        at_neg(); chk("t1_wren_off", WrEn, 0); chk("t1_addr_off", Address, 0);

        // port 1 read of address 7, RF returns 0xC3 with latency 1
        step(); REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 4'd7;
        at_neg(); chk("t2_gnt1", GNT1, 1); chk("t2_gnt0", GNT0, 0);
        step(); REQ1 = 1'b0;
        at_neg(); chk("t2_rden", RdEn, 1); chk("t2_addr", Address, 7);
        step(); RdData = 8'hC3; RdData_Valid = 1'b1;
        at_neg();
        step(); RdData = '0; RdData_Valid = 1'b0;
        at_neg(); chk("t2_rvld1", RVLD1, 1); chk("t2_rdata1", RDATA1, 8'hC3); chk("t2_rvld0", RVLD0, 0);
        step();
        at_neg(); chk("t2_rvld1_pulse", RVLD1, 0); chk("t2_rdata1_hold", RDATA1, 8'hC3);

        // both ports requesting writes continuously
        step();
        REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 4'd1; WDATA0 = 8'h11;
        REQ1 = 1'b1; WE1 = 1'b1; ADDR1 = 4'd2; WDATA1 = 8'h22;
        both_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            at_neg();
            if (GNT0) order.push_back(0);
            if (GNT1) order.push_back(1);
            if (GNT0 && GNT1) both_cnt++;
            step();
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
        chk("t3_ngrants", order.size(), 4);
        for (int i = 0; i < 4 && i < order.size(); i++) chk("t3_order", order[i], exp_order[i]);
        chk("t3_both_high", both_cnt, 0);

        // reset while waiting for read data, then a late return
        at_neg();
        step(); REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 4'd2;
        at_neg(); chk("t4_gnt0", GNT0, 1);
        step(); REQ0 = 1'b0;
        at_neg(); chk("t4_rden", RdEn, 1);
        step(); RST = 1'b1;
        at_neg();
        step(); RST = 1'b0; RdData = 8'hEE; RdData_Valid = 1'b1;
        at_neg();
        step(); RdData = '0; RdData_Valid = 1'b0;
        at_neg();
        chk("t4_rvld0", RVLD0, 0); chk("t4_rvld1", RVLD1, 0);
        chk("t4_rdata0", RDATA0, 0); chk("t4_rdata1", RDATA1, 0);
        chk("t4_rden", RdEn, 0); chk("t4_addr", Address, 0);

        // stray return in IDLE with no request
        step(); RdData = 8'h77; RdData_Valid = 1'b1;
        at_neg(); chk("t5_gnt0", GNT0, 0); chk("t5_gnt1", GNT1, 0);
        step(); RdData = '0; RdData_Valid = 1'b0;
        at_neg(); chk("t5_rvld0", RVLD0, 0); chk("t5_rvld1", RVLD1, 0); chk("t5_rdata0", RDATA0, 0);

        // read that the RF answers very late (or never, with the timeout build)
        step(); REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 4'd9;
        at_neg(); chk("t6_gnt1", GNT1, 1);
        step(); REQ1 = 1'b0;
        at_neg();
        rerr_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            at_neg();
            if (RERR1) rerr_seen++;
        end
        step(); RdData = 8'h3C; RdData_Valid = 1'b1;
        at_neg();
        step(); RdData = '0; RdData_Valid = 1'b0;
        at_neg();
`ifdef RF_ARB_TIMEOUT_EN
        chk("t6_rerr_pulses", rerr_seen, 1);
        chk("t6_rvld1", RVLD1, 0);
        chk("t6_rdata1", RDATA1, 0);
`else
        chk("t6_rerr_pulses", rerr_seen, 0);
        chk("t6_rvld1", RVLD1, 1);
        chk("t6_rdata1", RDATA1, 8'h3C);
`endif

        // next request must be granted within a few cycles
        step(); REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 4'd4; WDATA0 = 8'h44;
        got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            at_neg();
            if (GNT0) got = 1'b1;
            step();
        end
        REQ0 = 1'b0;
        chk("t7_granted", got, 1);
        at_neg();
        chk("t7_wren", WrEn, 1); chk("t7_wrdata", WrData, 8'h44);
        step(); at_neg();
        step(); at_neg();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "time limit");
    end

endmodule
